// File: rtl/risc16_seq_alu.sv
// Handshaked RiSC-16 ALU: registered result/flags, valid/ready on both sides,
// single-cycle ops plus an iterative shift-add unsigned multiply.
module risc16_seq_alu #(
  parameter int WORD_LENGTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WORD_LENGTH-1:0] src1,
  input  logic [WORD_LENGTH-1:0] src2,
  input  logic [2:0]             funct,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WORD_LENGTH-1:0] result,
  output logic [WORD_LENGTH-1:0] result_hi,
  output logic                   zero,
  output logic                   carry,
  output logic                   overflow
);

  localparam int SHAMT = $clog2(WORD_LENGTH);
  localparam int CNT_W = SHAMT + 1;
  localparam int MSB   = WORD_LENGTH - 1;

  localparam logic [2:0] OP_ADD = 3'd0, OP_NAND = 3'd1, OP_PASSA = 3'd2, OP_SUB = 3'd3,
                         OP_MUL = 3'd4, OP_SHL  = 3'd5, OP_SHR   = 3'd6, OP_SRA = 3'd7;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                   state_q, state_d;
  logic [WORD_LENGTH-1:0]   result_q, result_d, result_hi_q, result_hi_d;
  logic                     zero_q, zero_d, carry_q, carry_d, overflow_q, overflow_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [WORD_LENGTH-1:0]   mcand_q, mcand_d;
  logic [2*WORD_LENGTH-1:0] acc_q, acc_d;

  logic                     accept;
  logic [SHAMT-1:0]         shamt;
  logic [WORD_LENGTH:0]     add_s, sub_s, shl_s, mul_add;
  logic [WORD_LENGTH-1:0]   alu_res;
  logic                     alu_c, alu_v;
  logic [2*WORD_LENGTH-1:0] mul_step;

  assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign out_valid = (state_q == DONE);
  assign accept    = in_valid && in_ready && !flush;
  assign shamt     = src2[SHAMT-1:0];

  assign add_s = {1'b0, src1} + {1'b0, src2};
  assign sub_s = {1'b0, src1} - {1'b0, src2};
  assign shl_s = {1'b0, src1} << shamt;

  // Upper half accumulates the multiplicand; lower half holds the remaining multiplier bits.
  assign mul_add  = {1'b0, acc_q[2*WORD_LENGTH-1:WORD_LENGTH]} +
                    (acc_q[0] ? {1'b0, mcand_q} : '0);
  assign mul_step = {mul_add, acc_q[WORD_LENGTH-1:1]};

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (funct)
      OP_ADD: begin
        alu_res = add_s[MSB:0];
        alu_c   = add_s[WORD_LENGTH];
        alu_v   = (src1[MSB] == src2[MSB]) && (add_s[MSB] != src1[MSB]);
      end
      OP_SUB: begin
        alu_res = sub_s[MSB:0];
        alu_c   = sub_s[WORD_LENGTH];
        alu_v   = (src1[MSB] != src2[MSB]) && (sub_s[MSB] != src1[MSB]);
      end
      OP_NAND:  alu_res = ~(src1 & src2);
      OP_PASSA: alu_res = src1;
      OP_SHL: begin
        alu_res = shl_s[MSB:0];
        alu_c   = shl_s[WORD_LENGTH];
      end
      OP_SHR:  alu_res = src1 >> shamt;
      OP_SRA:  alu_res = $unsigned($signed(src1) >>> shamt);
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    result_d    = result_q;
    result_hi_d = result_hi_q;
    zero_d      = zero_q;
    carry_d     = carry_q;
    overflow_d  = overflow_q;
    cnt_d       = cnt_q;
    mcand_d     = mcand_q;
    acc_d       = acc_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (accept && funct == OP_MUL) begin
            mcand_d = src1;
            acc_d   = {{WORD_LENGTH{1'b0}}, src2};
            cnt_d   = CNT_W'(WORD_LENGTH);
            state_d = BUSY;
          end else if (accept) begin
            result_d    = alu_res;
            result_hi_d = '0;
            zero_d      = (alu_res == '0);
            carry_d     = alu_c;
            overflow_d  = alu_v;
            state_d     = DONE;
          end else if (state_q == DONE && out_ready) begin
            state_d = IDLE;
          end
        end
        BUSY: begin
          acc_d = mul_step;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            result_d    = mul_step[MSB:0];
            result_hi_d = mul_step[2*WORD_LENGTH-1:WORD_LENGTH];
            zero_d      = (mul_step[MSB:0] == '0);
            carry_d     = 1'b0;
            overflow_d  = 1'b0;
            state_d     = DONE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      result_q    <= '0;
      result_hi_q <= '0;
      zero_q      <= 1'b0;
      carry_q     <= 1'b0;
      overflow_q  <= 1'b0;
      cnt_q       <= '0;
      mcand_q     <= '0;
      acc_q       <= '0;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      zero_q      <= zero_d;
      carry_q     <= carry_d;
      overflow_q  <= overflow_d;
      cnt_q       <= cnt_d;
      mcand_q     <= mcand_d;
      acc_q       <= acc_d;
    end
  end

  assign result    = result_q;
  assign result_hi = result_hi_q;
  assign zero      = zero_q;
  assign carry     = carry_q;
  assign overflow  = overflow_q;

endmodule
